// File: rtl/fetch_stage.sv
// Instruction fetch stage with a one-outstanding imem handshake and the IF/ID pipeline register.
// Optional macro BRANCH_DELAY_SLOT_EN: a redirect keeps the F instruction as a delay slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  input  logic        jumpD,
  input  logic [31:0] pcjumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HELD = 2'd2} fetchStateT;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  fetchStateT  state, stateNext;
  logic [31:0] pcF, pcFNext;
  logic [31:0] reqAddr, reqAddrNext;
  logic [31:0] bufferInstr, bufferNext;
  logic [31:0] instrDNext, pcplus4DNext;
  logic [31:0] redirectTarget, pcPlus4F, nextPc, fetchWord;
  logic        stale, staleNext, validDNext;
  logic        available, advance, redirect, squash, transfer;
`ifdef BRANCH_DELAY_SLOT_EN
  logic        pending, pendingNext;
  logic [31:0] pendingTarget, pendingTargetNext;
`endif

  assign advance        = !stallF && !stallD;
  assign redirect       = !stallD && (jumpD || pcsrcD);
  assign redirectTarget = (jumpD ? pcjumpD : pcbranchD) & WORD_MASK;
  assign available      = !reset && (((state == WAIT) && imem_ack && !stale) || (state == HELD));
  assign fetchWord      = (state == HELD) ? bufferInstr : imem_rdata;
  assign pcPlus4F       = pcF + 32'd4;
  assign imem_req       = !reset && (state == WAIT);
  assign imem_addr      = reqAddr & WORD_MASK;
  assign fetch_busy     = !available;

  // With delay slots the F instruction survives a redirect and the target is deferred.
`ifdef BRANCH_DELAY_SLOT_EN
  assign squash = 1'b0;
  assign nextPc = redirect ? redirectTarget : (pending ? pendingTarget : pcPlus4F);
`else
  assign squash = redirect;
  assign nextPc = pcPlus4F;
`endif

  assign transfer = available && advance && !squash;

  always_comb begin
    stateNext    = state;
    pcFNext      = pcF;
    reqAddrNext  = reqAddr;
    staleNext    = stale;
    bufferNext   = bufferInstr;
    instrDNext   = instrD;
    pcplus4DNext = pcplus4D;
    validDNext   = validD;
`ifdef BRANCH_DELAY_SLOT_EN
    pendingNext       = pending;
    pendingTargetNext = pendingTarget;
`endif
    if (!stallD) begin
      instrDNext   = NOP_INSTR;
      pcplus4DNext = '0;
      validDNext   = 1'b0;
    end
    if (transfer) begin
      instrDNext   = fetchWord;
      pcplus4DNext = pcPlus4F;
      validDNext   = 1'b1;
      pcFNext      = nextPc;
      reqAddrNext  = nextPc;
      stateNext    = WAIT;
    end else if (squash) begin
      pcFNext   = redirectTarget;
      stateNext = WAIT;
      // An unanswered request cannot be withdrawn, so its ack is marked for discard.
      if ((state == WAIT) && !imem_ack) begin
        staleNext = 1'b1;
      end else begin
        staleNext   = 1'b0;
        reqAddrNext = redirectTarget;
      end
    end else begin
      case (state)
        IDLE: begin
          stateNext   = WAIT;
          reqAddrNext = pcF;
        end
        WAIT: begin
          if (available) begin
            bufferNext = imem_rdata;
            stateNext  = HELD;
          end else if (imem_ack && stale) begin
            staleNext   = 1'b0;
            reqAddrNext = pcF;
          end
        end
        HELD:    stateNext = HELD;
        default: stateNext = IDLE;
      endcase
    end
`ifdef BRANCH_DELAY_SLOT_EN
    if (transfer) begin
      pendingNext = 1'b0;
    end else if (redirect) begin
      pendingNext       = 1'b1;
      pendingTargetNext = redirectTarget;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pcF         <= RESET_PC & WORD_MASK;
      reqAddr     <= RESET_PC & WORD_MASK;
      stale       <= 1'b0;
      bufferInstr <= NOP_INSTR;
      instrD      <= NOP_INSTR;
      pcplus4D    <= '0;
      validD      <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pending       <= 1'b0;
      pendingTarget <= '0;
`endif
    end else begin
      state       <= stateNext;
      pcF         <= pcFNext;
      reqAddr     <= reqAddrNext;
      stale       <= staleNext;
      bufferInstr <= bufferNext;
      instrD      <= instrDNext;
      pcplus4D    <= pcplus4DNext;
      validD      <= validDNext;
`ifdef BRANCH_DELAY_SLOT_EN
      pending       <= pendingNext;
      pendingTarget <= pendingTargetNext;
`endif
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and drives a one-outstanding-request instruction-memory handshake.
- Applies stallF/stallD from the hazard unit and branch/jump redirects resolved in Decode.
- Produces instrD, pcplus4D and validD for Decode, and fetch_busy so the hazard logic can account for memory wait states.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven into D for a bubble.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- stallF  input  1  hold PC/fetch (from hazard unit)
- stallD  input  1  hold IF/ID register (from hazard unit)
- pcsrcD  input  1  branch taken, resolved in D
- pcbranchD  input  32  branch target
- jumpD  input  1  jump in D
- pcjumpD  input  32  jump target
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address, word aligned
- imem_ack  input  1  response valid (only meaningful while imem_req=1)
- imem_rdata  input  32  instruction word, valid with imem_ack
- instrD  output  32  instruction in Decode
- pcplus4D  output  32  PC+4 of instrD
- validD  output  1  instrD is a real instruction (0 = bubble)
- fetch_busy  output  1  F has no instruction available this cycle

Behaviour:
Reset (synchronous):
- pcF=RESET_PC, state=IDLE, req_addr=RESET_PC, stale=0, instrD=NOP_INSTR, pcplus4D=0, validD=0, pending redirect cleared.
- imem_req=0 and fetch_busy=1 during the reset cycle.
- Reset mid-request: the outstanding request is abandoned; an ack arriving after reset is ignored.

States:
- IDLE: entered only from reset; moves to WAIT next cycle with req_addr=pcF.
- WAIT: imem_req=1; imem_addr=req_addr, held stable until imem_ack.
- HELD: response captured in the internal buffer but not yet transferred; imem_req=0.

Availability and advance:
- An instruction is available when (WAIT & imem_ack & !stale) or HELD.
- advance = !stallF & !stallD.
- Transfer to D when available & advance: instrD=word, pcplus4D=pcF+4, validD=1, pcF=next PC, state=WAIT with req_addr=next PC.
- Back-to-back: a zero-wait memory (ack in the same cycle as req) gives 1 instruction/cycle.
- Available & !advance (from WAIT): capture into buffer, go to HELD, request nothing.
- stallD=1: instrD, pcplus4D and validD hold.
- stallD=0 with no transfer (not available, or stallF=1): D loads a bubble (instrD=NOP_INSTR, validD=0, pcplus4D=0).
- fetch_busy = !available.

Redirect:
- Honoured only when stallD=0. jumpD has priority over pcsrcD (target pcjumpD, else pcbranchD).
- The F instruction is squashed: it is not transferred and D loads a bubble.
- pcF=target; HELD buffer dropped; state=WAIT.
- If WAIT without ack: stale=1 and req_addr is kept until ack. That ack is discarded, stale clears, and the next cycle requests the target.
- If ack arrives in the redirect cycle: the word is discarded and the next cycle requests the target.
- Redirect while stallD=1: ignored; Decode re-presents it later.

Arithmetic and addressing:
- PC+4 is 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- imem_addr[1:0] is always 2'b00.
- Targets are used as given, with bits [1:0] forced to 0.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: a redirect does not squash F. The target is stored as pending. The next instruction transferred to D (the delay slot) gets pcplus4D = its own PC+4, but pcF loads the pending target instead of PC+4, and pending clears.
- Defined, delay slot transferring in the redirect cycle itself: pcF=target directly.
- Defined, stale logic: never invoked by a redirect.
- Undefined: squash behaviour as above.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory, no stalls -> imem_addr 0,4,8 on consecutive cycles; validD rises the cycle after the first ack; pcplus4D=4,8,12.
- Memory with 2 wait cycles per fetch -> fetch_busy=1 for 2 cycles per instruction; D gets bubbles (validD=0, instrD=0) in between; imem_addr stable while waiting.
- stallF=stallD=1 for 3 cycles with instr 32'h8C01_0004 acked -> state HELD, imem_req=0, instrD holds; after release it transfers with no new memory access.
- jumpD=1, pcjumpD=32'h0000_0040 while a request to 0x10 is outstanding (ack 2 cycles later) -> the 0x10 response is discarded, next imem_addr=0x40, D bubble; 0x40 instruction arrives with pcplus4D=0x44.
- BRANCH_DELAY_SLOT_EN defined, pcsrcD=1, pcbranchD=0x100 with instr at 0x8 in F -> 0x8 enters D (validD=1, pcplus4D=0xC), next imem_addr=0x100.
- Reset asserted while WAIT with ack pending -> outputs return to reset values; a late ack is ignored; first request after IDLE is to RESET_PC.
